// File: rtl/j2_io_input_port.sv
// j2_io_input_port
// Read-side I/O responder for the j2 core. Board inputs pass through a
// two-flop synchroniser and a per-bit debounce counter. Rising edges of the
// debounced level are latched as sticky events. Three registers (STATUS,
// EVENTS, INFO) are exposed at BASE_ADDR..BASE_ADDR+2. EVENTS clears on read
// and accepts write-one-to-clear. A new edge always beats a simultaneous
// clear, so no event is ever dropped.

`ifndef WIDTH
`define WIDTH 16
`endif

module j2_io_input_port #(
  parameter int          N_INPUTS        = 4,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter logic [15:0] BASE_ADDR       = 16'h0010
) (
  input  logic                clock,
  input  logic                active_low_reset,
  input  logic [N_INPUTS-1:0] pins,
  input  logic [15:0]         io_address,
  input  logic                io_read_enable,
  input  logic                io_write_enable,
  input  logic [`WIDTH-1:0]   data_out,
  output logic [`WIDTH-1:0]   io_data_in,
  output logic                event_pending
);

  // The counter only has to reach DEBOUNCE_CYCLES-1 before it is cleared, so
  // $clog2 bits are enough and it can never wrap.
  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] ADDR_STATUS = BASE_ADDR;
  localparam logic [15:0] ADDR_EVENTS = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADDR_INFO   = BASE_ADDR + 16'd2;

  logic [N_INPUTS-1:0]            sync_meta_q, sync_meta_d;
  logic [N_INPUTS-1:0]            sync_q, sync_d;
  logic [N_INPUTS-1:0]            stable_q, stable_d;
  logic [N_INPUTS-1:0]            stable_prev_q, stable_prev_d;
  logic [N_INPUTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_INPUTS-1:0]            events_q, events_d;
  logic [`WIDTH-1:0]              io_data_in_q, io_data_in_d;
  logic                           event_pending_q, event_pending_d;

  logic                hit_status;
  logic                hit_events;
  logic                hit_info;
  logic [`WIDTH-1:0]   read_value;
  logic [N_INPUTS-1:0] rise;
  logic [N_INPUTS-1:0] clr_read;
  logic [N_INPUTS-1:0] clr_write;

  // Only the low N_INPUTS write-data bits reach a register; the rest are
  // folded here so every port bit has a consumer.
  logic unused_data_bits;
  assign unused_data_bits = ^data_out;

  assign hit_status = (io_address == ADDR_STATUS);
  assign hit_events = (io_address == ADDR_EVENTS);
  assign hit_info   = (io_address == ADDR_INFO);

  // Two-flop synchroniser for the raw pins, plus a delayed copy of the
  // debounced level used for rising-edge detection.
  always_comb begin
    sync_meta_d   = pins;
    sync_d        = sync_meta_q;
    stable_prev_d = stable_q;
  end

  // Debounce: a bit must disagree with its stable level for DEBOUNCE_CYCLES
  // consecutive samples before the new level is accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Register map read mux; unmapped addresses read as zero.
  always_comb begin
    read_value = '0;
    if (hit_status) begin
      read_value[N_INPUTS-1:0] = stable_q;
    end else if (hit_events) begin
      read_value[N_INPUTS-1:0] = events_q;
    end else if (hit_info) begin
      read_value = `WIDTH'(N_INPUTS);
    end
  end

  // Sticky events: clear the bits just returned by a read and the bits
  // written as ones, then OR in new rising edges so a set beats a clear.
  always_comb begin
    rise            = stable_q & ~stable_prev_q;
    clr_read        = (io_read_enable && hit_events) ? events_q : '0;
    clr_write       = (io_write_enable && hit_events) ? data_out[N_INPUTS-1:0] : '0;
    events_d        = (events_q & ~(clr_read | clr_write)) | rise;
    event_pending_d = |events_q;
    io_data_in_d    = io_read_enable ? read_value : io_data_in_q;
  end

  // State registers with synchronous active-low reset; a reset discards any
  // debounce in progress.
  always_ff @(posedge clock) begin
    if (!active_low_reset) begin
      sync_meta_q     <= '0;
      sync_q          <= '0;
      stable_q        <= '0;
      stable_prev_q   <= '0;
      cnt_q           <= '0;
      events_q        <= '0;
      io_data_in_q    <= '0;
      event_pending_q <= 1'b0;
    end else begin
      sync_meta_q     <= sync_meta_d;
      sync_q          <= sync_d;
      stable_q        <= stable_d;
      stable_prev_q   <= stable_prev_d;
      cnt_q           <= cnt_d;
      events_q        <= events_d;
      io_data_in_q    <= io_data_in_d;
      event_pending_q <= event_pending_d;
    end
  end

  assign io_data_in    = io_data_in_q;
  assign event_pending = event_pending_q;

endmodule

// File: tb/tb_j2_io_input_port.sv
// tb_j2_io_input_port
// Directed bench for j2_io_input_port with DEBOUNCE_CYCLES=8, N_INPUTS=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// that follows each rising edge.

`ifndef WIDTH
`define WIDTH 16
`endif

module tb_j2_io_input_port;

  localparam int          N    = 4;
  localparam int          DB   = 8;
  localparam logic [15:0] BASE = 16'h0010;

  localparam logic [15:0] ADDR_STATUS = BASE;
  localparam logic [15:0] ADDR_EVENTS = BASE + 16'd1;
  localparam logic [15:0] ADDR_INFO   = BASE + 16'd2;
  localparam logic [15:0] ADDR_HOLE   = BASE + 16'd7;

  logic              clock = 1'b0;
  logic              active_low_reset;
  logic [N-1:0]      pins;
  logic [15:0]       io_address;
  logic              io_read_enable;
  logic              io_write_enable;
  logic [`WIDTH-1:0] data_out;
  logic [`WIDTH-1:0] io_data_in;
  logic              event_pending;

  int vectors     = 0;
  int miscompares = 0;

  j2_io_input_port #(
    .N_INPUTS        (N),
    .DEBOUNCE_CYCLES (DB),
    .BASE_ADDR       (BASE)
  ) dut (
    .clock            (clock),
    .active_low_reset (active_low_reset),
    .pins             (pins),
    .io_address       (io_address),
    .io_read_enable   (io_read_enable),
    .io_write_enable  (io_write_enable),
    .data_out         (data_out),
    .io_data_in       (io_data_in),
    .event_pending    (event_pending)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata);
    io_read_enable  = rd;
    io_write_enable = wr;
    io_address      = addr;
    data_out        = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr,
                            input logic [15:0] expected);
    applyStimulus(1'b1, 1'b0, addr, 16'h0000);
    tick();
    checkOutput(tag, io_data_in, expected);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    // Reset held three cycles with all pins high
    active_low_reset = 1'b0;
    pins             = 4'hF;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_cycles(3);
    checkOutput("reset io_data_in", io_data_in, 16'h0000);
    checkOutput("reset event_pending", 16'(event_pending), 16'h0000);

    // First read after release still sees a zero STATUS
    active_low_reset = 1'b1;
    read_check("status after reset", ADDR_STATUS, 16'h0000);
    pins = 4'h0;
    wait_cycles(6);

    // Debounce: stable rises at edge 10, so a STATUS read sampled at edge 10
    // still returns 0 and the read at edge 11 returns 1. Event set at edge
    // 11, event_pending at edge 12.
    $display("[TB] debounce");
    pins = 4'b0001;
    applyStimulus(1'b1, 1'b0, ADDR_STATUS, 16'h0000);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("debounce status c%0d", k), io_data_in,
                  (k >= 11) ? 16'h0001 : 16'h0000);
      checkOutput($sformatf("debounce pending c%0d", k), 16'(event_pending),
                  (k >= 12) ? 16'h0001 : 16'h0000);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_cycles(8);
    read_check("debounce events", ADDR_EVENTS, 16'h0001);
    wait_cycles(2);
    checkOutput("pending after events read", 16'(event_pending), 16'h0000);

    // Glitch on pin 1 shorter than the debounce window
    $display("[TB] glitch");
    pins = 4'b0011;
    wait_cycles(5);
    pins = 4'b0001;
    wait_cycles(12);
    read_check("glitch status", ADDR_STATUS, 16'h0001);
    read_check("glitch events", ADDR_EVENTS, 16'h0000);

    // Falling edges never create events; then two simultaneous rises
    $display("[TB] clear-on-read");
    pins = 4'b0000;
    wait_cycles(14);
    read_check("falling ignored status", ADDR_STATUS, 16'h0000);
    read_check("falling ignored events", ADDR_EVENTS, 16'h0000);
    pins = 4'b0101;
    wait_cycles(14);
    checkOutput("pending before read", 16'(event_pending), 16'h0001);
    read_check("cor first read", ADDR_EVENTS, 16'h0005);
    checkOutput("pending 1 cycle after read", 16'(event_pending), 16'h0001);
    tick();
    checkOutput("pending 2 cycles after read", 16'(event_pending), 16'h0000);
    read_check("cor second read", ADDR_EVENTS, 16'h0000);

    // Collision: the read lands on the edge where bit 2's rise sets its event
    $display("[TB] collision");
    pins = 4'b0001;
    wait_cycles(14);
    pins = 4'b0101;
    wait_cycles(10);
    read_check("collision read", ADDR_EVENTS, 16'h0000);
    read_check("after collision read", ADDR_EVENTS, 16'h0004);

    // W1C, write to another address ignored, INFO and unmapped reads
    $display("[TB] w1c and map");
    pins = 4'b0000;
    wait_cycles(14);
    pins = 4'b1111;
    wait_cycles(14);
    read_check("status all high", ADDR_STATUS, 16'h000F);
    applyStimulus(1'b0, 1'b1, ADDR_STATUS, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 1'b1, ADDR_EVENTS, 16'h0003);
    tick();
    checkOutput("data held across writes", io_data_in, 16'h000F);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    read_check("events after w1c", ADDR_EVENTS, 16'h000C);
    read_check("info", ADDR_INFO, 16'h0004);
    read_check("unmapped", ADDR_HOLE, 16'h0000);

    // Read and W1C-all in the same cycle as bit 3's rise: the read returns
    // the pending bit 0, both clears apply, and bit 3 survives.
    $display("[TB] read+write collision");
    pins = 4'b0110;
    wait_cycles(14);
    pins = 4'b0111;
    wait_cycles(3);
    pins = 4'b1111;
    wait_cycles(10);
    applyStimulus(1'b1, 1'b1, ADDR_EVENTS, 16'hFFFF);
    tick();
    checkOutput("read+w1c collision read", io_data_in, 16'h0001);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    read_check("after read+w1c", ADDR_EVENTS, 16'h0008);
    wait_cycles(2);
    checkOutput("final pending", 16'(event_pending), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
